// File: rtl/csa_tree_sched.sv
// Two-port round-robin sequencer for the shared CSA reduction tree, with a split carry-propagate add.
// Build option CSA_SCHED_FAST_ADD_EN: single-cycle full-width add (ADD_HI skipped).
module csa_tree_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_TERMS  = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic [DATA_WIDTH*NUM_TERMS-1:0] req0_terms,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic [DATA_WIDTH*NUM_TERMS-1:0] req1_terms,
  output logic [DATA_WIDTH*NUM_TERMS-1:0] tree_terms,
  input  logic [2*DATA_WIDTH-1:0]         tree_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH:0]             out_sum,
  output logic                            out_id,
  output logic                            busy,
  output logic [2:0]                      dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam int H  = DATA_WIDTH / 2;

  // Handshake rule: a transfer happens on any rising edge where valid and
  // ready are both high; ready never depends on the clock edge itself.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TREE   = 3'd1,
    S_ADD_LO = 3'd2,
    S_ADD_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [DW*NUM_TERMS-1:0]    tree_terms_q;
  logic [DW-1:0]              ps_q, pc_q;
  logic [DW:0]                sum_q;
  logic                       out_valid_q;
  logic                       id_q;
  logic                       last_id_q;
  logic                       grant1;
  logic                       hs;
`ifndef CSA_SCHED_FAST_ADD_EN
  logic [H-1:0]               lo_q;
  logic                       c_q;
  logic [H:0]                 lo_d;
  logic [H:0]                 hi_d;
`endif

  // req1 wins when alone, or when contending and req0 went last.
  assign grant1     = req1_valid && (!req0_valid || !last_id_q);
  assign hs         = (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant1;
  assign req1_ready = (state_q == S_IDLE) && grant1;

`ifndef CSA_SCHED_FAST_ADD_EN
  always_comb begin
    lo_d = {1'b0, ps_q[H-1:0]} + {1'b0, pc_q[H-1:0]};
    hi_d = {1'b0, ps_q[DW-1:H]} + {1'b0, pc_q[DW-1:H]} + {{H{1'b0}}, c_q};
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hs) state_d = S_TREE;
      S_TREE:   state_d = S_ADD_LO;
`ifdef CSA_SCHED_FAST_ADD_EN
      S_ADD_LO: state_d = S_DONE;
`else
      S_ADD_LO: state_d = S_ADD_HI;
      S_ADD_HI: state_d = S_DONE;
`endif
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tree_terms_q <= '0;
      ps_q         <= '0;
      pc_q         <= '0;
      sum_q        <= '0;
      out_valid_q  <= 1'b0;
      id_q         <= 1'b0;
      last_id_q    <= 1'b1;
`ifndef CSA_SCHED_FAST_ADD_EN
      lo_q         <= '0;
      c_q          <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (hs) begin
            tree_terms_q <= grant1 ? req1_terms : req0_terms;
            id_q         <= grant1;
            last_id_q    <= grant1;
          end
        end
        S_TREE: begin
          ps_q <= tree_result[DW-1:0];
          pc_q <= tree_result[2*DW-1:DW];
        end
`ifdef CSA_SCHED_FAST_ADD_EN
        S_ADD_LO: begin
          sum_q       <= {1'b0, ps_q} + {1'b0, pc_q};
          out_valid_q <= 1'b1;
        end
`else
        S_ADD_LO: begin
          lo_q <= lo_d[H-1:0];
          c_q  <= lo_d[H];
        end
        S_ADD_HI: begin
          sum_q       <= {hi_d, lo_q};
          out_valid_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tree_terms = tree_terms_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = sum_q;
  assign out_id     = id_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_csa_tree_sched.sv
// Self-checking bench for csa_tree_sched: behavioural tree model, vector table, scoreboard on results.
module tb_csa_tree_sched;

  localparam int DW = 64;
  localparam int NT = 12;
  localparam int TW = DW * NT;
`ifdef CSA_SCHED_FAST_ADD_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 4;
`endif

  typedef logic [TW-1:0] terms_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  terms_t        req0_terms, req1_terms;
  terms_t        tree_terms;
  logic [2*DW-1:0] tree_result;
  logic          out_valid, out_ready;
  logic [DW:0]   out_sum;
  logic          out_id;
  logic          busy;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [DW+1:0] exp_q[$];

  csa_tree_sched #(.DATA_WIDTH(DW), .NUM_TERMS(NT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_terms(req0_terms),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_terms(req1_terms),
    .tree_terms(tree_terms), .tree_result(tree_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_id(out_id), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Tree model: ps = term 0, pc = sum of the remaining terms (mod 2^DW).
  function automatic logic [DW-1:0] model_ps(input terms_t t);
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_pc(input terms_t t);
    logic [DW-1:0] acc;
    acc = '0;
    for (int i = 1; i < NT; i++) acc = acc + t[i*DW +: DW];
    return acc;
  endfunction

  function automatic logic [DW:0] model_sum(input terms_t t);
    return {1'b0, model_ps(t)} + {1'b0, model_pc(t)};
  endfunction

  assign tree_result = {model_pc(tree_terms), model_ps(tree_terms)};

  function automatic terms_t mk_terms(input logic [DW-1:0] t0, input logic [DW-1:0] t1);
    terms_t t;
    t = '0;
    t[DW-1:0]    = t0;
    t[2*DW-1:DW] = t1;
    return t;
  endfunction

  function automatic terms_t rand_terms();
    terms_t t;
    for (int i = 0; i < NT; i++) t[i*DW +: DW] = {$urandom, $urandom};
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, model_sum(req0_terms)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, model_sum(req1_terms)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", {62'd0, out_id, out_sum}, 128'h0);
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          chk("sb_result", {62'd0, out_id, out_sum}, {62'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input terms_t t);
    bit ok;
    ok = 0;
    if (id == 0) begin req0_terms = t; req0_valid = 1'b1; end
    else         begin req1_terms = t; req1_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) ok = 1;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
  endtask

  // Called in the cycle after the handshake; n counts cycles since it.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) chk("wait_out_timeout", 128'd0, 128'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int            id;
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    logic [DW:0]   exp_sum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int grants[$];
    logic [DW:0] held_sum;
    logic        held_id;
    bit          saw_valid;

    vecs[0] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   65'h1_0000_0000_0000_0000};
    vecs[1] = '{0, 64'h0,                   64'h0,                   65'h0};
    vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[3] = '{0, 64'h0000_0000_FFFF_FFFF, 64'h1,                   65'h0_0000_0001_0000_0000};
    vecs[4] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000};
    vecs[5] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 65'h0_2345_6789_ABCD_F001};

    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_terms = '0;
    req1_terms = '0;
    out_ready  = 1'b1;

    // Reset held two cycles with both valids high.
    tick();
    tick();
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_out_id", {127'd0, out_id}, 128'd0);
    chk("rst_out_sum", {63'd0, out_sum}, 128'd0);
    chk("rst_tree_terms_lo", tree_terms[127:0], 128'd0);
    chk("rst_state", {125'd0, dbg_state}, 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req0_ready", {127'd0, req0_ready}, 128'd1);
    chk("post_rst_req1_ready", {127'd0, req1_ready}, 128'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Table-driven single requests.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].id, mk_terms(vecs[v].t0, vecs[v].t1));
      wait_out(n);
      chk($sformatf("vec%0d_latency", v), 128'(n), 128'(LAT));
      chk($sformatf("vec%0d_sum", v), {63'd0, out_sum}, {63'd0, vecs[v].exp_sum});
      chk($sformatf("vec%0d_id", v), {127'd0, out_id}, 128'(vecs[v].id));
      tick();
      chk($sformatf("vec%0d_idle", v), {127'd0, busy}, 128'd0);
    end

    // Contention: both valid continuously, grants must alternate from 0.
    do_reset(1);
    req0_terms = rand_terms();
    req1_terms = rand_terms();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 200 && grants.size() < 4; c++) begin
      int g;
      g = -1;
      @(negedge clk);
      if (req0_valid && req0_ready) g = 0;
      if (req1_valid && req1_ready) g = 1;
      tick();
      if (g == 0) req0_terms = rand_terms();
      if (g == 1) req1_terms = rand_terms();
      if (g >= 0) grants.push_back(g);
      if (grants.size() == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("contention_grant_count", 128'(grants.size()), 128'd4);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("contention_grant%0d", k), 128'(grants[k]), 128'(k % 2));
    for (int c = 0; c < 50 && (busy || exp_q.size() != 0); c++) tick();
    chk("contention_drained", 128'(exp_q.size()), 128'd0);

    // Backpressure in DONE with both requesters pending.
    out_ready = 1'b0;
    send(0, rand_terms());
    wait_out(n);
    chk("bp_latency", 128'(n), 128'(LAT));
    held_sum = out_sum;
    held_id  = out_id;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_sum_stable", {63'd0, out_sum}, {63'd0, held_sum});
      chk("bp_id_stable", {127'd0, out_id}, {127'd0, held_id});
      chk("bp_busy", {127'd0, busy}, 128'd1);
      chk("bp_readies", {126'd0, req0_ready, req1_ready}, 128'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    chk("bp_idle_after_ready", {127'd0, busy}, 128'd0);
    chk("bp_valid_cleared", {127'd0, out_valid}, 128'd0);

    // Reset during ADD_LO of a req0 operation; last_id must return to 1.
    send(0, rand_terms());
    tick();
    chk("mid_rst_in_add_lo", {125'd0, dbg_state}, 128'd2);
    do_reset(1);
    saw_valid = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) saw_valid = 1;
      tick();
    end
    chk("mid_rst_no_valid", {127'd0, saw_valid}, 128'd0);
    req0_terms = rand_terms();
    req1_terms = rand_terms();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_grant0", {126'd0, req0_ready, req1_ready}, 128'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_out(n);
    chk("mid_rst_latency", 128'(n), 128'(LAT));
    chk("mid_rst_id", {127'd0, out_id}, 128'd0);
    tick();
    tick();
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
